// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator (640x480 @ 60 Hz by default).
// Produces pixel coordinates, sync pulses, blanking, line/frame strobes and a
// wrapping completed-frame counter. Every output comes straight from a flop;
// the decoded outputs are computed from next-state coordinates so they line up
// with the registered x/y on the same clock.
module vga_timing #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit thresholds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic [10:0] x_next_wide;
  logic [10:0] y_next_wide;
  logic        x_wrap;
  logic        y_wrap;
  logic        line_end_next;

  // Next-state raster position: x wraps every line, y advances on x wrap
  always_comb begin
    x_wrap = ({1'b0, x} == H_LAST);
    y_wrap = ({1'b0, y} == V_LAST);
    x_next = x_wrap ? 10'd0 : x + 10'd1;
    y_next = y;
    if (x_wrap) begin
      y_next = y_wrap ? 10'd0 : y + 10'd1;
    end
    x_next_wide   = {1'b0, x_next};
    y_next_wide   = {1'b0, y_next};
    line_end_next = (x_next_wide == H_LAST);
  end

  // Counters and registered decodes; reset overrides every wrap and increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      blank       <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      x <= x_next;
      y <= y_next;
      if (x_wrap && y_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
      hsync <= (x_next_wide >= HS_START && x_next_wide < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // y_next only moves on x wrap, so vsync only changes at line starts
      vsync <= (y_next_wide >= VS_START && y_next_wide < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      blank     <= (x_next_wide >= H_VIS) || (y_next_wide >= V_VIS);
      line_end  <= line_end_next;
      frame_end <= line_end_next && (y_next_wide == V_LAST);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing. Three instances share one
// reset: defaults (d), full-width lines with a short frame (m) so the vsync
// pulse is reachable, and a tiny 8x6 raster with active-high sync (s) for
// frame wrap and counter rollover.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] x_d, y_d, x_m, y_m, x_s, y_s;
  logic       hs_d, vs_d, bl_d, le_d, fe_d;
  logic       hs_m, vs_m, bl_m, le_m, fe_m;
  logic       hs_s, vs_s, bl_s, le_s, fe_s;
  logic [7:0] fc_d, fc_m, fc_s;

  vga_timing dut_d (
    .clk(clk), .rst_n(rst_n), .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d),
    .blank(bl_d), .line_end(le_d), .frame_end(fe_d), .frame_count(fc_d)
  );

  vga_timing #(
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .x(x_m), .y(y_m), .hsync(hs_m), .vsync(vs_m),
    .blank(bl_m), .line_end(le_m), .frame_end(fe_m), .frame_count(fc_m)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
    .blank(bl_s), .line_end(le_s), .frame_end(fe_s), .frame_count(fc_s)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;        // clocks since last reset release (raster index)
  int vlow_m = 0;   // clocks with dut_m vsync low since mid-frame reset
  int fe_cnt_s = 0; // dut_s frame_end strobes since mid-frame reset

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Expected outputs from the raster index k and the instance geometry
  task automatic check_one(input string n,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp, input logic sa,
      input logic [9:0] ox, input logic [9:0] oy, input logic ohs, input logic ovs,
      input logic obl, input logic ole, input logic ofe, input logic [7:0] ofc);
    int ht, vt, ex, ey, ef;
    logic ehs, evs;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    ex  = k % ht;
    ey  = (k / ht) % vt;
    ef  = (k / (ht * vt)) % 256;
    ehs = (ex >= ha + hfp && ex < ha + hfp + hsw) ? sa : ~sa;
    evs = (ey >= va + vfp && ey < va + vfp + vsw) ? sa : ~sa;
    chk({n, ".x"}, 32'(ox), 32'(ex));
    chk({n, ".y"}, 32'(oy), 32'(ey));
    chk({n, ".frame_count"}, 32'(ofc), 32'(ef));
    chk({n, ".hsync"}, 32'(ohs), 32'(ehs));
    chk({n, ".vsync"}, 32'(ovs), 32'(evs));
    chk({n, ".blank"}, 32'(obl), 32'(ex >= ha || ey >= va));
    chk({n, ".line_end"}, 32'(ole), 32'(ex == ht - 1));
    chk({n, ".frame_end"}, 32'(ofe), 32'(ex == ht - 1 && ey == vt - 1));
  endtask

  // One clock: advance the index on the edge, compare all instances mid-cycle
  task automatic tick();
    @(posedge clk);
    k = rst_n ? k + 1 : 0;
    @(negedge clk);
    if (rst_n && !vs_m) vlow_m++;
    if (fe_s) fe_cnt_s++;
    check_one("d", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
              x_d, y_d, hs_d, vs_d, bl_d, le_d, fe_d, fc_d);
    check_one("m", 640, 16, 96, 48, 3, 1, 2, 1, 1'b0,
              x_m, y_m, hs_m, vs_m, bl_m, le_m, fe_m, fc_m);
    check_one("s", 4, 1, 2, 1, 3, 1, 1, 1, 1'b1,
              x_s, y_s, hs_s, vs_s, bl_s, le_s, fe_s, fc_s);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) tick();
    chk("reset.hsync_d", 32'(hs_d), 32'd1);
    chk("reset.vsync_d", 32'(vs_d), 32'd1);
    chk("reset.hsync_s_active_high", 32'(hs_s), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("first_clock.x_d", 32'(x_d), 32'd1);
    repeat (9) tick();
    chk("after_10.x_d", 32'(x_d), 32'd10);

    // Mid-frame reset on dut_s at frame_count=3, y=2, x=5
    while (k < 165) tick();
    chk("pre_reset.fc_s", 32'(fc_s), 32'd3);
    chk("pre_reset.y_s", 32'(y_s), 32'd2);
    chk("pre_reset.x_s", 32'(x_s), 32'd5);
    rst_n = 1'b0;
    tick();
    chk("mid_reset.x_s", 32'(x_s), 32'd0);
    chk("mid_reset.y_s", 32'(y_s), 32'd0);
    chk("mid_reset.fc_s", 32'(fc_s), 32'd0);
    chk("mid_reset.x_d", 32'(x_d), 32'd0);
    rst_n = 1'b1;
    vlow_m   = 0;
    fe_cnt_s = 0;
    tick();
    chk("resume.x_s", 32'(x_s), 32'd1);

    // Line wrap on defaults: x=799,y=5 -> x=0,y=6 with vsync steady
    while (k < 4799) tick();
    chk("wrap_pre.x_d", 32'(x_d), 32'd799);
    chk("wrap_pre.y_d", 32'(y_d), 32'd5);
    chk("wrap_pre.line_end_d", 32'(le_d), 32'd1);
    tick();
    chk("wrap_post.x_d", 32'(x_d), 32'd0);
    chk("wrap_post.y_d", 32'(y_d), 32'd6);
    chk("wrap_post.vsync_d", 32'(vs_d), 32'd1);

    // dut_m frame is 5600 clocks; vsync low for two full lines
    while (k < 5600) tick();
    chk("vsync_width_m", 32'(vlow_m), 32'd1600);

    // dut_s: 256 frames of 48 clocks, counter rolls over
    while (k < 12287) tick();
    chk("last_clock.fc_s", 32'(fc_s), 32'd255);
    chk("last_clock.frame_end_s", 32'(fe_s), 32'd1);
    tick();
    chk("rollover.fc_s", 32'(fc_s), 32'd0);
    chk("rollover.x_s", 32'(x_s), 32'd0);
    chk("rollover.y_s", 32'(y_s), 32'd0);
    chk("frame_end_count_s", 32'(fe_cnt_s), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
